// File: rtl/stream_pkg.sv
// stream_pkg: shared stream stage and arbitration mode types.
package stream_pkg;
  typedef enum logic {
    STREAM_PIPELINE_MODE_REGISTERED,
    STREAM_PIPELINE_MODE_TRANSPARENT
  } stream_pipeline_mode_t;
  typedef enum logic {
    STREAM_SELECT_MODE_ROUND_ROBIN,
    STREAM_SELECT_MODE_HIGH_PRIORITY
  } stream_select_mode_t;
endpackage

// File: rtl/stream_intf.sv
// stream_intf: valid/ready stream with a WIDTH-bit payload.
interface stream_intf #(
  parameter int WIDTH = 8
) ();
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport in (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/stream_merge_arbiter.sv
// stream_merge_arbiter: round-robin/priority grant with optional packet lock (STREAM_MERGE_PACKET_LOCK_EN).
module stream_merge_arbiter
  import stream_pkg::*;
#(
  parameter stream_select_mode_t SELECT_MODE = STREAM_SELECT_MODE_ROUND_ROBIN,
  parameter int PORTS = 2,
  parameter int ID_WIDTH = $clog2(PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    req,
  input  logic                advance,
  input  logic [PORTS-1:0]    last,
  output logic [PORTS-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_valid
);
  logic [ID_WIDTH-1:0] ptr_q, ptr_d, base, cand, pick;
  logic pick_valid;
  // Scan farthest-to-nearest so the port closest after base is written last and wins.
  always_comb begin
    base = (SELECT_MODE == STREAM_SELECT_MODE_ROUND_ROBIN) ? ptr_q : ID_WIDTH'(PORTS - 1);
    cand = '0;
    pick = '0;
    pick_valid = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(base) + k) % PORTS);
      if (req[cand]) begin
        pick = cand;
        pick_valid = 1'b1;
      end
    end
  end
`ifdef STREAM_MERGE_PACKET_LOCK_EN
  logic lock_q, lock_d;
  logic [ID_WIDTH-1:0] lock_idx_q, lock_idx_d;
  always_comb begin
    grant_idx = lock_q ? lock_idx_q : pick;
    grant_valid = lock_q ? req[lock_idx_q] : pick_valid;
    lock_d = advance ? ~last[grant_idx] : lock_q;
    lock_idx_d = advance ? grant_idx : lock_idx_q;
    ptr_d = (advance & last[grant_idx]) ? grant_idx : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  always_comb begin
    grant_idx = pick;
    grant_valid = pick_valid;
    ptr_d = advance ? pick : ptr_q;
  end
`endif
  always_ff @(posedge clk) begin
    ptr_q <= !rst ? ID_WIDTH'(PORTS - 1) : ptr_d;
  end
  always_comb begin
    grant = '0;
    grant[grant_idx] = grant_valid;
  end
endmodule

// File: rtl/stream_stage.sv
// stream_stage: one-entry full-throughput register slice, or a wire in transparent mode.
module stream_stage
  import stream_pkg::*;
#(
  parameter CLOCK_INFO = 'b0,
  parameter stream_pipeline_mode_t PIPELINE_MODE = STREAM_PIPELINE_MODE_REGISTERED,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic unused_clock_info;
  assign unused_clock_info = |CLOCK_INFO;
  if (PIPELINE_MODE == STREAM_PIPELINE_MODE_REGISTERED) begin : g_reg
    logic valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    always_comb begin
      in_ready = rst & (~valid_q | out_ready);
      valid_d = (in_valid & in_ready) | (valid_q & ~out_ready);
      data_d = (in_valid & in_ready) ? in_data : data_q;
    end
    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= 1'b0;
        data_q <= '0;
      end else begin
        valid_q <= valid_d;
        data_q <= data_d;
      end
    end
    assign out_valid = valid_q;
    assign out_data = data_q;
  end else begin : g_thru
    always_comb begin
      in_ready = rst & out_ready;
      out_valid = rst & in_valid;
      out_data = rst ? in_data : '0;
    end
  end
endmodule

// File: rtl/stream_merge.sv
// stream_merge: N:1 stream arbiter tagging each beat with its source port; STREAM_MERGE_PACKET_LOCK_EN keeps packets whole.
module stream_merge
  import stream_pkg::*;
#(
  parameter CLOCK_INFO = 'b0,
  parameter stream_pipeline_mode_t PIPELINE_MODE = STREAM_PIPELINE_MODE_REGISTERED,
  parameter stream_select_mode_t STREAM_SELECT_MODE = STREAM_SELECT_MODE_ROUND_ROBIN,
  parameter int PORTS = 2,
  parameter int ID_WIDTH = $clog2(PORTS),
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  stream_intf.in              stream_in [PORTS],
  input  logic [PORTS-1:0]    stream_in_last,
  stream_intf.out             stream_out,
  output logic [ID_WIDTH-1:0] stream_out_id
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] payload;
  } entry_t;
  if (PORTS < 2) begin : g_ports_chk
    $error("stream_merge: PORTS must be greater than 1");
  end
  logic [PORTS-1:0] req, grant;
  logic [DATA_WIDTH-1:0] payload [PORTS];
  logic [ID_WIDTH-1:0] grant_idx;
  logic grant_valid, stage_ready;
  entry_t stage_in, stage_out;
  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign req[i] = stream_in[i].valid;
    assign payload[i] = stream_in[i].data;
    assign stream_in[i].ready = grant[i] & stage_ready;
  end
  stream_merge_arbiter #(
    .SELECT_MODE(STREAM_SELECT_MODE),
    .PORTS(PORTS),
    .ID_WIDTH(ID_WIDTH)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .advance(grant_valid & stage_ready),
    .last(stream_in_last),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid)
  );
  assign stage_in = '{id: grant_idx, payload: payload[grant_idx]};
  stream_stage #(
    .CLOCK_INFO(CLOCK_INFO),
    .PIPELINE_MODE(PIPELINE_MODE),
    .WIDTH($bits(entry_t))
  ) u_stage (
    .clk(clk),
    .rst(rst),
    .in_valid(grant_valid),
    .in_ready(stage_ready),
    .in_data(stage_in),
    .out_valid(stream_out.valid),
    .out_ready(stream_out.ready),
    .out_data(stage_out)
  );
  assign stream_out.data = stage_out.payload;
  assign stream_out_id = stage_out.id;
endmodule
